// File: rtl/core_run_monitor_pkg.sv
// Shared types and widths for the RV64I run supervisor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_run_monitor_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 32;
    localparam int VIOL_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_PASS     = 3'd1,
        CAUSE_TIMEOUT  = 3'd2,
        CAUSE_HANG     = 3'd3,
        CAUSE_X0_FAULT = 3'd4,
        CAUSE_PC_X     = 3'd5
    } cause_e;

    // Saturating add of this cycle's violation count onto the running total.
    function automatic logic [VIOL_W-1:0] viol_sat_add(input logic [VIOL_W-1:0] acc,
                                                       input logic [2:0]        inc);
        logic [VIOL_W:0] sum;
        sum = {1'b0, acc} + {{(VIOL_W-2){1'b0}}, inc};
        return sum[VIOL_W] ? {VIOL_W{1'b1}} : sum[VIOL_W-1:0];
    endfunction

endpackage

// File: rtl/run_mon_hang_det.sv
// PC hang detector: flags the valid fetch sample on which the same PC has been seen HANG_CYCLES times in a row.
// Latency: hang is combinational on the current sample; streak state updates on the next edge.
// Backpressure: none; pc_valid low freezes the streak (stalls neither advance nor reset it).
// Ports: clk, rst (async active-low), clear (restart for a new run), pc_valid, pc -> hang (pulse).
module run_mon_hang_det #(
    parameter int XLEN        = 64,
    parameter int HANG_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc,
    output logic            hang
);

    localparam int STREAK_W = $clog2(HANG_CYCLES + 1);
    localparam logic [STREAK_W-1:0] STREAK_FIRE = STREAK_W'(HANG_CYCLES - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(HANG_CYCLES);

    logic [XLEN-1:0]     last_pc;
    logic                prev_valid;
    logic [STREAK_W-1:0] streak;
    logic                same_pc;

    assign same_pc = prev_valid && (pc == last_pc);

    // Fires on the sample that would take the streak to HANG_CYCLES.
    assign hang = pc_valid && same_pc && (streak == STREAK_FIRE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc    <= '0;
            prev_valid <= 1'b0;
            streak     <= '0;
        end else if (clear) begin
            last_pc    <= '0;
            prev_valid <= 1'b0;
            streak     <= '0;
        end else if (pc_valid) begin
            if (same_pc) begin
                // Saturate so a run that lingers after the hang cannot wrap and re-fire.
                if (streak != STREAK_MAX) begin
                    streak <= streak + STREAK_W'(1);
                end
            end else begin
                prev_valid <= 1'b1;
                last_pc    <= pc;
                streak     <= STREAK_W'(1);
            end
        end
    end

endmodule

// File: rtl/core_run_monitor.sv
// Run supervisor for the pipelined RV64I core: watches fetch PC and NUM_WB writeback ports, latches the first end-of-run cause, drains, then holds a sticky done/pass verdict.
// Latency: events are combinational on the current cycle; cause/state update on the next edge; done rises DRAIN_CYCLES edges after DRAIN entry.
// Backpressure: none; purely observational, start is ignored outside IDLE/DONE.
// Ports: clk, rst (async active-low), start, pc_valid, pc, wb_we/wb_addr/wb_data (port i at slice i)
//        -> state, cause, done, pass, cycle_count, x0_viol_count.
// Build option: define RUN_MON_X0_FATAL_EN to make a nonzero write to x0 during RUN end the run with X0_FAULT.
module core_run_monitor
    import core_run_monitor_pkg::*;
#(
    parameter int              XLEN           = 64,
    parameter int              NUM_WB         = 1,
    parameter int              TIMEOUT_CYCLES = 1000,
    parameter int              HANG_CYCLES    = 16,
    parameter int              DRAIN_CYCLES   = 10,
    parameter int              SIG_REG        = 31,
    parameter logic [XLEN-1:0] SIG_VALUE      = XLEN'(64'h7FF)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         pc_valid,
    input  logic [XLEN-1:0]              pc,
    input  logic [NUM_WB-1:0]            wb_we,
    input  logic [NUM_WB*REG_ADDR_W-1:0] wb_addr,
    input  logic [NUM_WB*XLEN-1:0]       wb_data,
    output logic [1:0]                   state,
    output logic [2:0]                   cause,
    output logic                         done,
    output logic                         pass,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [VIOL_W-1:0]            x0_viol_count
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REG_ADDR_W-1:0] SIG_ADDR     = REG_ADDR_W'(SIG_REG);

    state_e             state_q, state_d;
    cause_e             cause_q, cause_d;
    cause_e             event_cause;
    logic               run_clear;
    logic               sig_hit;
    logic [2:0]         viol_n;
    logic               hang;
    logic               pc_x;
    logic               x0_fault;
    logic               timeout_hit;
    logic [DRAIN_W-1:0] drain_cnt;

    // Per-port signature match and x0-violation tally.
    always_comb begin
        sig_hit = 1'b0;
        viol_n  = 3'd0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_we[i] && (wb_addr[i*REG_ADDR_W +: REG_ADDR_W] == SIG_ADDR) &&
                (wb_data[i*XLEN +: XLEN] == SIG_VALUE)) begin
                sig_hit = 1'b1;
            end
            // Zero-data writes to x0 are pipeline bubbles, not violations.
            if (wb_we[i] && (wb_addr[i*REG_ADDR_W +: REG_ADDR_W] == '0) &&
                (wb_data[i*XLEN +: XLEN] != '0)) begin
                viol_n = viol_n + 3'd1;
            end
        end
    end

`ifdef RUN_MON_X0_FATAL_EN
    assign x0_fault = (viol_n != 3'd0);
`else
    assign x0_fault = 1'b0;
`endif

    // X/Z on a valid PC only means something in a 4-state simulator.
`ifdef SYNTHESIS
    assign pc_x = 1'b0;
`else
    assign pc_x = pc_valid && $isunknown(pc);
`endif

    assign timeout_hit = (cycle_count == TIMEOUT_LAST);

    run_mon_hang_det #(
        .XLEN        (XLEN),
        .HANG_CYCLES (HANG_CYCLES)
    ) u_hang_det (
        .clk      (clk),
        .rst      (rst),
        .clear    (run_clear),
        .pc_valid (pc_valid),
        .pc       (pc),
        .hang     (hang)
    );

    // Simultaneous events resolve in fixed priority order.
    always_comb begin
        event_cause = CAUSE_NONE;
        if (pc_x) begin
            event_cause = CAUSE_PC_X;
        end else if (x0_fault) begin
            event_cause = CAUSE_X0_FAULT;
        end else if (sig_hit) begin
            event_cause = CAUSE_PASS;
        end else if (hang) begin
            event_cause = CAUSE_HANG;
        end else if (timeout_hit) begin
            event_cause = CAUSE_TIMEOUT;
        end
    end

    // FSM next-state and cause latch.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        run_clear = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    cause_d   = CAUSE_NONE;
                    run_clear = 1'b1;
                end
            end
            RUN: begin
                if (event_cause != CAUSE_NONE) begin
                    state_d = DRAIN;
                    cause_d = event_cause;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Counters: cleared on run entry; cycle_count advances only in RUN,
    // x0 violations are tallied through RUN and DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count   <= '0;
            x0_viol_count <= '0;
            drain_cnt     <= '0;
        end else begin
            if (run_clear) begin
                cycle_count   <= '0;
                x0_viol_count <= '0;
            end else begin
                if ((state_q == RUN) && (cycle_count != {CNT_W{1'b1}})) begin
                    cycle_count <= cycle_count + CNT_W'(1);
                end
                if ((state_q == RUN) || (state_q == DRAIN)) begin
                    x0_viol_count <= viol_sat_add(x0_viol_count, viol_n);
                end
            end
            // Loaded on DRAIN entry; DONE is taken when it reads 1, giving exactly DRAIN_CYCLES in DRAIN.
            if ((state_q == RUN) && (state_d == DRAIN)) begin
                drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
            end else if ((state_q == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

    assign state = state_q;
    assign cause = cause_q;
    assign done  = (state_q == DONE);
    assign pass  = done && (cause_q == CAUSE_PASS);

endmodule

// File: tb/tb_core_run_monitor.sv
module tb_core_run_monitor;

    localparam int NUM_WB = 2;
    localparam int DRAIN  = 10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] C_NONE    = 3'd0;
    localparam logic [2:0] C_PASS    = 3'd1;
    localparam logic [2:0] C_TIMEOUT = 3'd2;
    localparam logic [2:0] C_HANG    = 3'd3;
    localparam logic [2:0] C_X0      = 3'd4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 pc_valid = 1'b0;
    logic [63:0]          pc = '0;
    logic [NUM_WB-1:0]    wb_we = '0;
    logic [NUM_WB*5-1:0]  wb_addr = '0;
    logic [NUM_WB*64-1:0] wb_data = '0;
    logic [1:0]           state;
    logic [2:0]           cause;
    logic                 done;
    logic                 pass;
    logic [31:0]          cycle_count;
    logic [15:0]          x0_viol_count;

    core_run_monitor #(
        .XLEN   (64),
        .NUM_WB (NUM_WB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pc_valid      (pc_valid),
        .pc            (pc),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .state         (state),
        .cause         (cause),
        .done          (done),
        .pass          (pass),
        .cycle_count   (cycle_count),
        .x0_viol_count (x0_viol_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One run per record: when the signature / x0 write lands, how the PC behaves,
    // and the verdict the run must end with.
    typedef struct {
        int         sig_cyc;   // RUN cycle of x31=0x7FF write, -1 none
        int         sig_port;
        int         x0_cyc;    // RUN cycle of x0=5 write on port 0, -1 none
        int         mode;      // 0 PC+4 each cycle, 1 held 0x80, 2 held then moves to 0x84 at sample 10
        logic [2:0] exp_cause;
        int         exp_cnt;
        int         exp_x0;    // includes the one violation injected during DRAIN
    } vec_t;

    typedef struct {
        logic [2:0] cause;
        int         cnt;
        int         x0;
        logic       pass;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic drive_idle();
        start    = 1'b0;
        pc_valid = 1'b0;
        wb_we    = '0;
        wb_addr  = '0;
        wb_data  = '0;
        wb_we[0] = 1'b1;   // x0 <= 0 bubble, never a violation
    endtask

    task automatic set_port(input int p, input logic [4:0] a, input logic [63:0] d);
        wb_we[p]          = 1'b1;
        wb_addr[p*5 +: 5] = a;
        wb_data[p*64 +: 64] = d;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   k;
        int   vcount;
        int   j;
        int   drain_start;
        logic stall;
        string tag;
        tag = $sformatf("v%0d", idx);

        e.cause = v.exp_cause;
        e.cnt   = v.exp_cnt;
        e.x0    = v.exp_x0;
        e.pass  = (v.exp_cause == C_PASS);
        sb.push_back(e);

        @(negedge clk);
        drive_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_run_entry"}, state, S_RUN);
        check({tag, "_cnt_clear"}, cycle_count, 0);

        k = 0;
        vcount = 0;
        while (state == S_RUN && k < 1100) begin
            drive_idle();
            start = (k == 20);   // must be ignored in RUN
            if (v.mode == 0) begin
                pc_valid = 1'b1;
                pc       = 64'h1000 + 64'(4 * k);
            end else begin
                stall    = (k == 3) || (k == 7) || (k == 12);
                pc_valid = !stall;
                pc       = (v.mode == 2 && vcount >= 9) ? 64'h84 : 64'h80;
                if (!stall) vcount++;
            end
            if (k == v.x0_cyc)  set_port(0, 5'd0, 64'd5);
            if (k == v.sig_cyc) set_port(v.sig_port, 5'd31, 64'h7FF);
            @(negedge clk);
            k++;
        end
        check({tag, "_drain_entry"}, state, S_DRAIN);
        check({tag, "_cause_at_drain"}, cause, v.exp_cause);

        // Late events in DRAIN: signature, x0 violation and start must not change the verdict.
        drain_start = cyc;
        drive_idle();
        start    = 1'b1;
        pc_valid = 1'b1;
        pc       = 64'h80;
        set_port(0, 5'd0, 64'd7);
        set_port(1, 5'd31, 64'h7FF);
        @(negedge clk);
        drive_idle();
        j = 0;
        while (!done && j < 40) begin
            @(negedge clk);
            j++;
        end
        check({tag, "_drain_len"}, cyc - drain_start, DRAIN);

        e = sb.pop_front();
        check({tag, "_cause"}, cause, e.cause);
        check({tag, "_cycle_count"}, cycle_count, e.cnt);
        check({tag, "_x0_count"}, x0_viol_count, e.x0);
        check({tag, "_pass"}, pass, e.pass);
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, {state, done}, {S_DONE, 1'b1});
    endtask

    initial begin
        vecs[0] = '{50,  0, -1, 0, C_PASS,    51,   1};
        vecs[1] = '{-1,  0, -1, 0, C_TIMEOUT, 1000, 1};
        vecs[2] = '{999, 1, -1, 0, C_PASS,    1000, 1};
`ifdef RUN_MON_X0_FATAL_EN
        vecs[3] = '{30,  1, 30, 0, C_X0,      31,   2};
        vecs[4] = '{40,  0, 10, 0, C_X0,      11,   2};
`else
        vecs[3] = '{30,  1, 30, 0, C_PASS,    31,   2};
        vecs[4] = '{40,  0, 10, 0, C_PASS,    41,   2};
`endif
        vecs[5] = '{-1,  0, -1, 1, C_HANG,    19,   1};
        vecs[6] = '{-1,  0, -1, 2, C_HANG,    28,   1};

        drive_idle();
        #1;
        check("rst_state", state, S_IDLE);
        check("rst_cause", cause, C_NONE);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_x0_count", x0_viol_count, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold", state, S_IDLE);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Reset asserted mid-DRAIN must return everything at once, without a clock edge.
        @(negedge clk);
        drive_idle();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 40 && state == S_RUN; k++) begin
            drive_idle();
            pc_valid = 1'b1;
            pc = 64'h2000 + 64'(4 * k);
            if (k == 2) set_port(0, 5'd0, 64'd9);
            if (k == 5) set_port(1, 5'd31, 64'h7FF);
            @(negedge clk);
        end
        drive_idle();
        repeat (3) @(negedge clk);
        check("pre_rst_state", state, S_DRAIN);
        check("pre_rst_cycle_count", cycle_count, 6);
        check("pre_rst_x0_count", x0_viol_count, 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_state", state, S_IDLE);
        check("mid_rst_cause", cause, C_NONE);
        check("mid_rst_done_pass", {done, pass}, 2'b00);
        check("mid_rst_cycle_count", cycle_count, 0);
        check("mid_rst_x0_count", x0_viol_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", state, S_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
